hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline.
- Produces the stall and clear controls for the fetch and decode pipeline registers.
- Produces forwarding selects for the execute-stage ALU operands and the decode-stage branch comparator.
- Sequences the multi-cycle multiply/divide unit with a busy counter, stalling decode until HI/LO results are ready.

Parameters:
- MUL_CYCLES, 4, cycles a multiply occupies the mul/div unit (≥1).
- DIV_CYCLES, 32, cycles a divide occupies the mul/div unit (≥1).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- reg_rs_id_D / reg_rt_id_D  in  5  source register ids in decode
- reg_rs_id_E / reg_rt_id_E  in  5  source register ids in execute
- write_reg_E / write_reg_M / write_reg_W  in  5  destination ids per stage
- reg_write_E / reg_write_M / reg_write_W  in  1  destination write enables
- mem_to_reg_E / mem_to_reg_M  in  1  load in stage
- branch_D  in  1  branch in decode
- pc_src_D  in  1  branch taken or jump resolved in decode
- hilo_use_D  in  1  decode instruction reads HI/LO or is a mul/div
- muldiv_start_E  in  1  mul/div issued in execute
- muldiv_is_div_E  in  1  1=divide, 0=multiply
- stall_F  out  1  hold PC
- stall_D  out  1  hold fetch/decode pipeline register
- flush_D  out  1  clear fetch/decode pipeline register
- flush_E  out  1  clear decode/execute pipeline register (bubble)
- forward_a_E / forward_b_E  out  2  00=regfile, 01=W result, 10=M ALU result
- forward_a_D / forward_b_D  out  1  1=forward M ALU result to branch comparator
- muldiv_busy  out  1  mul/div unit occupied
- muldiv_done  out  1  one-cycle pulse, final busy cycle

Behaviour:
- Register 0 never matches for forwarding or stall purposes. Any comparison involving id 0 is false.
- forward_a_E:
  - 10 if reg_write_M and write_reg_M==reg_rs_id_E;
  - else 01 if reg_write_W and write_reg_W==reg_rs_id_E;
  - else 00.
  - M has priority over W. forward_b_E is identical using reg_rt_id_E.
- forward_a_D = reg_write_M and write_reg_M==reg_rs_id_D. forward_b_D uses reg_rt_id_D. All forwarding outputs are combinational, zero latency.
- lw_stall = mem_to_reg_E and write_reg_E matches reg_rs_id_D or reg_rt_id_D.
- branch_stall = branch_D and either:
  - reg_write_E and write_reg_E matches rs_D/rt_D, or
  - mem_to_reg_M and write_reg_M matches rs_D/rt_D.
- Mul/div FSM states:
  - IDLE→BUSY on muldiv_start_E. Counter is loaded with (is_div ? DIV_CYCLES : MUL_CYCLES) − 1.
  - BUSY decrements each cycle. At count 0 it returns to IDLE on the next edge.
  - muldiv_busy = (state==BUSY).
  - muldiv_done = BUSY and count==0, combinational.
  - Start at edge t gives busy high for exactly N cycles and done in the Nth.
  - muldiv_start_E while BUSY is ignored: no reload, state unchanged.
- muldiv_stall = hilo_use_D and (muldiv_busy or muldiv_start_E). A start in E with a dependent instruction in D stalls immediately.
- stall_F = stall_D = lw_stall | branch_stall | muldiv_stall.
- flush_E = stall_D | reset.
- flush_D = (pc_src_D & ~stall_D) | reset. A stall takes priority over a redirect.
- Reset (synchronous) results:
  - state=IDLE, counter=0.
  - flush_D=flush_E=1 while reset is high.
  - All other outputs 0.
  - Reset mid-BUSY aborts the operation; muldiv_done does not pulse.

Optional Feature:
- Macro HAZARD_PERF_COUNTERS_EN.
- When defined, adds outputs stall_count (32), flush_count (32) and muldiv_stall_count (32).
- Each counter increments on every cycle its condition (stall_D, flush_D excluding reset, muldiv_stall) is high and reset is low.
- Counters saturate at 0xFFFFFFFF and clear to 0 on reset.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Forwarding:
  - reg_write_M=1, write_reg_M=5, reg_write_W=1, write_reg_W=5, rs_E=5 → forward_a_E=10.
  - Drop reg_write_M → 01.
  - write ids=0, rs_E=0 → 00.
- Load-use: mem_to_reg_E=1, write_reg_E=8, rt_D=8 → stall_F=stall_D=flush_E=1, flush_D=0. Next cycle with mem_to_reg_E=0 → all 0.
- Branch: branch_D=1, reg_write_E=1, write_reg_E=3, rs_D=3, pc_src_D=1 → stall_D=1, flush_D=0. Once the hazard clears → flush_D=1 for one cycle; write_reg_M=3 gives forward_a_D=1.
- Multiply: muldiv_start_E=1, is_div=0 at cycle 0 → muldiv_busy high cycles 1–4, done at cycle 4. hilo_use_D=1 stalls cycles 0–4 and releases at 5. Start during busy is ignored.
- Divide with reset: start div, assert reset at busy cycle 10 → next cycle busy=0, done never pulses. flush_D=flush_E=1 while reset is high.
- Perf counters (macro on): 3 load-use stalls plus 1 taken branch → stall_count=3, flush_count=1. Preset counter to 0xFFFFFFFF via 2^32 stalls (or force) → holds.

Source files
------------

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: pipeline-side view of the hazard controller (stage ids, enables, stall/flush/forward controls).
// Latency: none, pure signal bundle.
// Backpressure: none, the stall/flush controls carried here are the pipeline's backpressure.
// Optional: HAZARD_PERF_COUNTERS_EN adds the three 32-bit performance counter outputs.
interface hazard_unit_if;
    // Decode / execute source ids
    logic [4:0] reg_rs_id_D;
    logic [4:0] reg_rt_id_D;
    logic [4:0] reg_rs_id_E;
    logic [4:0] reg_rt_id_E;
    // Destinations per stage
    logic [4:0] write_reg_E;
    logic [4:0] write_reg_M;
    logic [4:0] write_reg_W;
    logic       reg_write_E;
    logic       reg_write_M;
    logic       reg_write_W;
    logic       mem_to_reg_E;
    logic       mem_to_reg_M;
    // Control flow and mul/div
    logic       branch_D;
    logic       pc_src_D;
    logic       hilo_use_D;
    logic       muldiv_start_E;
    logic       muldiv_is_div_E;
    // Controls back to the pipeline
    logic       stall_F;
    logic       stall_D;
    logic       flush_D;
    logic       flush_E;
    logic [1:0] forward_a_E;
    logic [1:0] forward_b_E;
    logic       forward_a_D;
    logic       forward_b_D;
    logic       muldiv_busy;
    logic       muldiv_done;
`ifdef HAZARD_PERF_COUNTERS_EN
    logic [31:0] stall_count;
    logic [31:0] flush_count;
    logic [31:0] muldiv_stall_count;
`endif

    // Pipeline side: drives stage state, consumes controls
    modport master (
`ifdef HAZARD_PERF_COUNTERS_EN
        input  stall_count, flush_count, muldiv_stall_count,
`endif
        output reg_rs_id_D, reg_rt_id_D, reg_rs_id_E, reg_rt_id_E,
        output write_reg_E, write_reg_M, write_reg_W,
        output reg_write_E, reg_write_M, reg_write_W,
        output mem_to_reg_E, mem_to_reg_M, branch_D, pc_src_D,
        output hilo_use_D, muldiv_start_E, muldiv_is_div_E,
        input  stall_F, stall_D, flush_D, flush_E,
        input  forward_a_E, forward_b_E, forward_a_D, forward_b_D,
        input  muldiv_busy, muldiv_done
    );

    // Hazard unit side
    modport slave (
`ifdef HAZARD_PERF_COUNTERS_EN
        output stall_count, flush_count, muldiv_stall_count,
`endif
        input  reg_rs_id_D, reg_rt_id_D, reg_rs_id_E, reg_rt_id_E,
        input  write_reg_E, write_reg_M, write_reg_W,
        input  reg_write_E, reg_write_M, reg_write_W,
        input  mem_to_reg_E, mem_to_reg_M, branch_D, pc_src_D,
        input  hilo_use_D, muldiv_start_E, muldiv_is_div_E,
        output stall_F, stall_D, flush_D, flush_E,
        output forward_a_E, forward_b_E, forward_a_D, forward_b_D,
        output muldiv_busy, muldiv_done
    );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush/forwarding control and mul/div busy sequencing for the 5-stage pipeline.
// Latency: forwarding, stall and flush are combinational; mul/div stays busy N cycles after the start edge.
// Backpressure: holds F/D on load-use, branch-operand and HI/LO hazards; a start while busy is dropped.
// Optional: HAZARD_PERF_COUNTERS_EN adds saturating stall/flush/muldiv-stall counters.
module hazard_unit #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input logic          clock,
    input logic          reset,
    hazard_unit_if.slave hz
);
    localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    md_state_t        state_q;
    logic [CNT_W-1:0] count_q;

    logic       lw_stall;
    logic       branch_stall;
    logic       muldiv_stall;
    logic       stall;
    logic       redirect;
    logic       busy_raw;
    logic [1:0] fwd_a_e;
    logic [1:0] fwd_b_e;
    logic       fwd_a_d;
    logic       fwd_b_d;

    // Register 0 is hardwired, so a destination of 0 never creates a dependency
    function automatic logic id_hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    // Mul/div occupancy: count holds remaining busy cycles minus one; starts while busy are dropped
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hz.muldiv_start_E) begin
                        state_q <= BUSY;
                        count_q <= hz.muldiv_is_div_E ? DIV_LOAD : MUL_LOAD;
                    end
                end
                BUSY: begin
                    if (count_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        count_q <= count_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Hazard detection and operand forwarding selects; the more recent M result wins over W
    always_comb begin
        busy_raw     = (state_q == BUSY);
        lw_stall     = hz.mem_to_reg_E &&
                       (id_hit(hz.write_reg_E, hz.reg_rs_id_D) || id_hit(hz.write_reg_E, hz.reg_rt_id_D));
        branch_stall = hz.branch_D &&
                       ((hz.reg_write_E &&
                         (id_hit(hz.write_reg_E, hz.reg_rs_id_D) || id_hit(hz.write_reg_E, hz.reg_rt_id_D))) ||
                        (hz.mem_to_reg_M &&
                         (id_hit(hz.write_reg_M, hz.reg_rs_id_D) || id_hit(hz.write_reg_M, hz.reg_rt_id_D))));
        // A start in E already blocks a dependent instruction sitting in D
        muldiv_stall = hz.hilo_use_D && (busy_raw || hz.muldiv_start_E) && !reset;
        stall        = (lw_stall || branch_stall || muldiv_stall) && !reset;
        // A stalled branch must not redirect yet: the stall wins over pc_src
        redirect     = hz.pc_src_D && !stall && !reset;

        fwd_a_e = 2'b00;
        if (hz.reg_write_M && id_hit(hz.write_reg_M, hz.reg_rs_id_E)) begin
            fwd_a_e = 2'b10;
        end else if (hz.reg_write_W && id_hit(hz.write_reg_W, hz.reg_rs_id_E)) begin
            fwd_a_e = 2'b01;
        end
        fwd_b_e = 2'b00;
        if (hz.reg_write_M && id_hit(hz.write_reg_M, hz.reg_rt_id_E)) begin
            fwd_b_e = 2'b10;
        end else if (hz.reg_write_W && id_hit(hz.write_reg_W, hz.reg_rt_id_E)) begin
            fwd_b_e = 2'b01;
        end
        fwd_a_d = hz.reg_write_M && id_hit(hz.write_reg_M, hz.reg_rs_id_D);
        fwd_b_d = hz.reg_write_M && id_hit(hz.write_reg_M, hz.reg_rt_id_D);
    end

    // While reset is high only the two flushes are asserted; everything else reads 0
    assign hz.stall_F     = stall;
    assign hz.stall_D     = stall;
    assign hz.flush_E     = stall || reset;
    assign hz.flush_D     = redirect || reset;
    assign hz.forward_a_E = reset ? 2'b00 : fwd_a_e;
    assign hz.forward_b_E = reset ? 2'b00 : fwd_b_e;
    assign hz.forward_a_D = fwd_a_d && !reset;
    assign hz.forward_b_D = fwd_b_d && !reset;
    assign hz.muldiv_busy = busy_raw && !reset;
    assign hz.muldiv_done = busy_raw && (count_q == '0) && !reset;

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] md_cnt_q, md_cnt_d;

    // Saturating event counters; the reset-forced flush is not counted
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        md_cnt_d    = md_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (redirect && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
        if (muldiv_stall && (md_cnt_q != 32'hFFFF_FFFF)) md_cnt_d = md_cnt_q + 32'd1;
    end

    // Counter state
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            md_cnt_q    <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            md_cnt_q    <= md_cnt_d;
        end
    end

    assign hz.stall_count        = stall_cnt_q;
    assign hz.flush_count        = flush_cnt_q;
    assign hz.muldiv_stall_count = md_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed scenarios plus randomized traffic against a behavioural model.
// Latency: outputs sampled mid-cycle, model state advanced on each rising edge.
// Backpressure: n/a.
module tb_hazard_unit;
    localparam int MUL_N = 4;
    localparam int DIV_N = 32;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   rem    = 0;   // model: busy cycles still to come, including the current one

    hazard_unit_if hz();

    hazard_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clock (clock),
        .reset (reset),
        .hz    (hz)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic bit hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    // {stall_F, stall_D, flush_D, flush_E, fwd_a_E, fwd_b_E, fwd_a_D, fwd_b_D, busy, done}
    function automatic logic [11:0] observed();
        return {hz.stall_F, hz.stall_D, hz.flush_D, hz.flush_E, hz.forward_a_E, hz.forward_b_E,
                hz.forward_a_D, hz.forward_b_D, hz.muldiv_busy, hz.muldiv_done};
    endfunction

    function automatic logic [11:0] model_out();
        bit lw, br, md, st;
        logic [1:0] fa, fb;
        if (reset) return 12'b0011_0000_0000;
        lw = hz.mem_to_reg_E && (hit(hz.write_reg_E, hz.reg_rs_id_D) || hit(hz.write_reg_E, hz.reg_rt_id_D));
        br = hz.branch_D &&
             ((hz.reg_write_E && (hit(hz.write_reg_E, hz.reg_rs_id_D) || hit(hz.write_reg_E, hz.reg_rt_id_D))) ||
              (hz.mem_to_reg_M && (hit(hz.write_reg_M, hz.reg_rs_id_D) || hit(hz.write_reg_M, hz.reg_rt_id_D))));
        md = hz.hilo_use_D && (rem > 0 || hz.muldiv_start_E);
        st = lw || br || md;
        fa = (hz.reg_write_M && hit(hz.write_reg_M, hz.reg_rs_id_E)) ? 2'd2 :
             (hz.reg_write_W && hit(hz.write_reg_W, hz.reg_rs_id_E)) ? 2'd1 : 2'd0;
        fb = (hz.reg_write_M && hit(hz.write_reg_M, hz.reg_rt_id_E)) ? 2'd2 :
             (hz.reg_write_W && hit(hz.write_reg_W, hz.reg_rt_id_E)) ? 2'd1 : 2'd0;
        return {st, st, hz.pc_src_D && !st, st, fa, fb,
                hz.reg_write_M && hit(hz.write_reg_M, hz.reg_rs_id_D),
                hz.reg_write_M && hit(hz.write_reg_M, hz.reg_rt_id_D),
                rem > 0, rem == 1};
    endfunction

    // Advance one clock and the model's occupancy
    task automatic step();
        @(posedge clock);
        if (reset) rem = 0;
        else if (rem > 0) rem = rem - 1;
        else if (hz.muldiv_start_E) rem = hz.muldiv_is_div_E ? DIV_N : MUL_N;
        #1;
    endtask

    task automatic clear_inputs();
        hz.reg_rs_id_D = '0; hz.reg_rt_id_D = '0; hz.reg_rs_id_E = '0; hz.reg_rt_id_E = '0;
        hz.write_reg_E = '0; hz.write_reg_M = '0; hz.write_reg_W = '0;
        hz.reg_write_E = 1'b0; hz.reg_write_M = 1'b0; hz.reg_write_W = 1'b0;
        hz.mem_to_reg_E = 1'b0; hz.mem_to_reg_M = 1'b0;
        hz.branch_D = 1'b0; hz.pc_src_D = 1'b0; hz.hilo_use_D = 1'b0;
        hz.muldiv_start_E = 1'b0; hz.muldiv_is_div_E = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        // Inputs that would otherwise stall and forward must be masked during reset
        hz.reg_write_M = 1'b1; hz.write_reg_M = 5'd5; hz.reg_rs_id_E = 5'd5;
        hz.mem_to_reg_E = 1'b1; hz.write_reg_E = 5'd8; hz.reg_rt_id_D = 5'd8;
        #3;
        checks++;
        if (observed() !== 12'b0011_0000_0000) begin
            errors++; $display("FAIL reset_outputs: got %b expected %b", observed(), 12'b0011_0000_0000);
        end
        step();
        clear_inputs();
        reset = 1'b0;
        #3;
        checks++;
        if (observed() !== 12'd0) begin
            errors++; $display("FAIL post_reset_idle: got %b expected %b", observed(), 12'd0);
        end
        step();
    endtask

    task automatic test_forwarding();
        clear_inputs();
        hz.reg_write_M = 1'b1; hz.write_reg_M = 5'd5;
        hz.reg_write_W = 1'b1; hz.write_reg_W = 5'd5; hz.reg_rs_id_E = 5'd5;
        #3;
        checks++;
        if (hz.forward_a_E !== 2'b10) begin
            errors++; $display("FAIL fwd_m_priority: got %b expected 10", hz.forward_a_E);
        end
        step();
        hz.reg_write_M = 1'b0;
        #3;
        checks++;
        if (hz.forward_a_E !== 2'b01) begin
            errors++; $display("FAIL fwd_w: got %b expected 01", hz.forward_a_E);
        end
        step();
        hz.reg_write_M = 1'b1; hz.write_reg_M = 5'd0; hz.write_reg_W = 5'd0;
        hz.reg_rs_id_E = 5'd0; hz.reg_rt_id_E = 5'd0;
        #3;
        checks++;
        if ({hz.forward_a_E, hz.forward_b_E} !== 4'b0000) begin
            errors++; $display("FAIL fwd_reg0: got %b expected 0000", {hz.forward_a_E, hz.forward_b_E});
        end
        step();
        hz.write_reg_M = 5'd9; hz.reg_rt_id_E = 5'd9; hz.write_reg_W = 5'd7; hz.reg_rs_id_E = 5'd7;
        #3;
        checks++;
        if ({hz.forward_a_E, hz.forward_b_E} !== 4'b0110) begin
            errors++; $display("FAIL fwd_split: got %b expected 0110", {hz.forward_a_E, hz.forward_b_E});
        end
        step();
    endtask

    task automatic test_load_use();
        clear_inputs();
        hz.mem_to_reg_E = 1'b1; hz.write_reg_E = 5'd8; hz.reg_rt_id_D = 5'd8;
        #3;
        checks++;
        if ({hz.stall_F, hz.stall_D, hz.flush_E, hz.flush_D} !== 4'b1110) begin
            errors++; $display("FAIL load_use_stall: got %b expected 1110",
                               {hz.stall_F, hz.stall_D, hz.flush_E, hz.flush_D});
        end
        step();
        hz.mem_to_reg_E = 1'b0;
        #3;
        checks++;
        if ({hz.stall_F, hz.stall_D, hz.flush_E, hz.flush_D} !== 4'b0000) begin
            errors++; $display("FAIL load_use_release: got %b expected 0000",
                               {hz.stall_F, hz.stall_D, hz.flush_E, hz.flush_D});
        end
        step();
    endtask

    task automatic test_branch();
        clear_inputs();
        hz.branch_D = 1'b1; hz.pc_src_D = 1'b1;
        hz.reg_write_E = 1'b1; hz.write_reg_E = 5'd3; hz.reg_rs_id_D = 5'd3;
        #3;
        checks++;
        if ({hz.stall_D, hz.flush_D} !== 2'b10) begin
            errors++; $display("FAIL branch_stall_E: got %b expected 10", {hz.stall_D, hz.flush_D});
        end
        step();
        hz.reg_write_E = 1'b0; hz.write_reg_E = 5'd0;
        hz.reg_write_M = 1'b1; hz.write_reg_M = 5'd3;
        #3;
        checks++;
        if ({hz.stall_D, hz.flush_D, hz.forward_a_D} !== 3'b011) begin
            errors++; $display("FAIL branch_redirect: got %b expected 011", {hz.stall_D, hz.flush_D, hz.forward_a_D});
        end
        step();
        hz.branch_D = 1'b0; hz.pc_src_D = 1'b0;
        #3;
        checks++;
        if (hz.flush_D !== 1'b0) begin
            errors++; $display("FAIL branch_flush_one_cycle: got %b expected 0", hz.flush_D);
        end
        step();
        hz.branch_D = 1'b1; hz.reg_write_M = 1'b0; hz.mem_to_reg_M = 1'b1;
        hz.reg_rs_id_D = 5'd0; hz.reg_rt_id_D = 5'd3;
        #3;
        checks++;
        if (hz.stall_D !== 1'b1) begin
            errors++; $display("FAIL branch_stall_M_load: got %b expected 1", hz.stall_D);
        end
        step();
    endtask

    task automatic test_multiply();
        clear_inputs();
        hz.muldiv_start_E = 1'b1; hz.hilo_use_D = 1'b1;
        #3;
        checks++;
        if ({hz.stall_D, hz.muldiv_busy, hz.muldiv_done} !== 3'b100) begin
            errors++; $display("FAIL mul_cycle0: got %b expected 100",
                               {hz.stall_D, hz.muldiv_busy, hz.muldiv_done});
        end
        step();
        for (int c = 1; c <= 6; c++) begin
            // A divide start during busy must be ignored
            hz.muldiv_start_E  = (c == 2);
            hz.muldiv_is_div_E = (c == 2);
            #3;
            checks++;
            if ({hz.stall_D, hz.muldiv_busy, hz.muldiv_done} !== {c <= 4, c <= 4, c == 4}) begin
                errors++; $display("FAIL mul_cycle%0d: got %b expected %b", c,
                                   {hz.stall_D, hz.muldiv_busy, hz.muldiv_done}, {c <= 4, c <= 4, c == 4});
            end
            step();
        end
    endtask

    task automatic test_divide_reset();
        clear_inputs();
        hz.muldiv_start_E = 1'b1; hz.muldiv_is_div_E = 1'b1;
        #3;
        step();
        hz.muldiv_start_E = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            #3;
            checks++;
            if ({hz.muldiv_busy, hz.muldiv_done} !== 2'b10) begin
                errors++; $display("FAIL div_busy_c%0d: got %b expected 10", c, {hz.muldiv_busy, hz.muldiv_done});
            end
            step();
        end
        reset = 1'b1;
        #3;
        checks++;
        if ({hz.flush_D, hz.flush_E, hz.muldiv_done} !== 3'b110) begin
            errors++; $display("FAIL div_reset_flush: got %b expected 110", {hz.flush_D, hz.flush_E, hz.muldiv_done});
        end
        step();
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #3;
            checks++;
            if ({hz.muldiv_busy, hz.muldiv_done} !== 2'b00) begin
                errors++; $display("FAIL div_aborted_c%0d: got %b expected 00", c, {hz.muldiv_busy, hz.muldiv_done});
            end
            step();
        end
    endtask

    task automatic test_random();
        logic [11:0] exp_v;
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            hz.reg_rs_id_D = 5'($urandom_range(0, 7)); hz.reg_rt_id_D = 5'($urandom_range(0, 7));
            hz.reg_rs_id_E = 5'($urandom_range(0, 7)); hz.reg_rt_id_E = 5'($urandom_range(0, 7));
            hz.write_reg_E = 5'($urandom_range(0, 7)); hz.write_reg_M = 5'($urandom_range(0, 7));
            hz.write_reg_W = 5'($urandom_range(0, 7));
            hz.reg_write_E = 1'($urandom); hz.reg_write_M = 1'($urandom); hz.reg_write_W = 1'($urandom);
            hz.mem_to_reg_E = ($urandom_range(0, 3) == 0); hz.mem_to_reg_M = ($urandom_range(0, 3) == 0);
            hz.branch_D = ($urandom_range(0, 2) == 0); hz.pc_src_D = ($urandom_range(0, 2) == 0);
            hz.hilo_use_D = ($urandom_range(0, 3) == 0);
            hz.muldiv_start_E = ($urandom_range(0, 7) == 0); hz.muldiv_is_div_E = ($urandom_range(0, 3) == 0);
            #3;
            exp_v = model_out();
            checks++;
            if (observed() !== exp_v) begin
                errors++; $display("FAIL random_%0d: got %b expected %b (rem=%0d)", i, observed(), exp_v, rem);
            end
            step();
        end
        reset = 1'b0;
    endtask

`ifdef HAZARD_PERF_COUNTERS_EN
    task automatic test_perf();
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        hz.mem_to_reg_E = 1'b1; hz.write_reg_E = 5'd8; hz.reg_rt_id_D = 5'd8;
        for (int i = 0; i < 3; i++) step();
        clear_inputs();
        hz.pc_src_D = 1'b1;
        step();
        clear_inputs();
        #3;
        checks++;
        if ({hz.stall_count, hz.flush_count, hz.muldiv_stall_count} !== {32'd3, 32'd1, 32'd0}) begin
            errors++; $display("FAIL perf_counts: got %0d/%0d/%0d expected 3/1/0",
                               hz.stall_count, hz.flush_count, hz.muldiv_stall_count);
        end
        step();
    endtask
`endif

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_multiply();
        test_divide_reset();
        test_random();
`ifdef HAZARD_PERF_COUNTERS_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
